// File: rtl/avalon_mem_arbiter_pkg.sv
// Shared Avalon-MM types and widths for the memory-side arbiter and its helpers.
package avalon_mem_arbiter_pkg;

  localparam int unsigned AVN_ADDR_W = 32;
  localparam int unsigned AVN_DATA_W = 32;

  typedef struct packed {
    logic                    read;
    logic                    write;
    logic [AVN_ADDR_W-1:0]   address;
    logic [AVN_DATA_W-1:0]   writedata;
    logic [AVN_DATA_W/8-1:0] byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [AVN_DATA_W-1:0] readdata;
    logic                  waitrequest;
  } avalon_resp_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/avalon_mem_arbiter_rr_arbiter_core.sv
// Combinational winner select: rotating search from last_grant+1 (round-robin)
// or from index 0 (fixed priority).
module rr_arbiter_core
  import avalon_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic [NUM_PORTS-1:0]         i_req,
  input  logic [$clog2(NUM_PORTS)-1:0] i_last_grant,
  output logic [$clog2(NUM_PORTS)-1:0] o_winner,
  output logic                         o_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0] w_start;

  assign w_start = ((RR_ENABLE != 0) && (i_last_grant != IDX_W'(NUM_PORTS - 1)))
                   ? i_last_grant + 1'b1 : '0;

  // Scan farthest-first so the requester closest to w_start overwrites last.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    o_winner = '0;
    o_valid  = 1'b0;
    v_idx    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      v_idx = IDX_W'((32'(w_start) + NUM_PORTS - 1 - k) % NUM_PORTS);
      if (i_req[v_idx]) begin
        o_winner = v_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one memory-side Avalon-MM port among NUM_PORTS masters; one grant is
// held until its transfer completes, then a 1-cycle IDLE gap re-arbitrates.
module avalon_mem_arbiter
  import avalon_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  avalon_req_t  [NUM_PORTS-1:0]        host_avn_req,
  output avalon_resp_t [NUM_PORTS-1:0]        host_avn_resp,
  output avalon_req_t                         mem_avn_req,
  input  avalon_resp_t                        mem_avn_resp,
  output logic         [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                                busy
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_last_grant;
  logic [IDX_W-1:0]     w_winner;
  logic [NUM_PORTS-1:0] w_req;
  logic                 w_any;
  logic                 w_own_req;
  logic                 w_done;

  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_req[i] = host_avn_req[i].read | host_avn_req[i].write;
    end
  end

  rr_arbiter_core #(
    .NUM_PORTS (NUM_PORTS),
    .RR_ENABLE (RR_ENABLE)
  ) u_rr_arbiter_core (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_valid      (w_any)
  );

  assign w_own_req = w_req[r_owner];
  assign w_done    = w_own_req & ~mem_avn_resp.waitrequest;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_winner;
      end
      if (r_state == GRANT && w_done) begin
        r_last_grant <= r_owner;
      end
    end
  end

  // An owner dropping its request mid-grant releases the bus without updating last_grant.
  always_comb begin
    w_state_nxt = r_state;
    mem_avn_req = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      host_avn_resp[i].readdata    = '0;
      host_avn_resp[i].waitrequest = 1'b1;
    end
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        mem_avn_req            = host_avn_req[r_owner];
        host_avn_resp[r_owner] = mem_avn_resp;
        if (!w_own_req || w_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign grant_id = r_owner;
  assign busy     = (r_state == GRANT);

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed checks of avalon_mem_arbiter: a round-robin and a fixed-priority
// instance share the same host and memory stimulus.
module tb_avalon_mem_arbiter;
  import avalon_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  avalon_req_t  [1:0] host_req;
  avalon_resp_t [1:0] rr_resp;
  avalon_resp_t [1:0] fp_resp;
  avalon_req_t        rr_mem_req;
  avalon_req_t        fp_mem_req;
  avalon_resp_t       mem_resp;
  logic [0:0]         rr_gid;
  logic [0:0]         fp_gid;
  logic               rr_busy;
  logic               fp_busy;

  int vectors     = 0;
  int miscompares = 0;

  localparam int RW = $bits(avalon_req_t);

  always #5 clk = ~clk;

  avalon_mem_arbiter #(.NUM_PORTS(2), .RR_ENABLE(1)) dut_rr (
    .clk           (clk),
    .rst           (rst),
    .host_avn_req  (host_req),
    .host_avn_resp (rr_resp),
    .mem_avn_req   (rr_mem_req),
    .mem_avn_resp  (mem_resp),
    .grant_id      (rr_gid),
    .busy          (rr_busy)
  );

  avalon_mem_arbiter #(.NUM_PORTS(2), .RR_ENABLE(0)) dut_fp (
    .clk           (clk),
    .rst           (rst),
    .host_avn_req  (host_req),
    .host_avn_resp (fp_resp),
    .mem_avn_req   (fp_mem_req),
    .mem_avn_resp  (mem_resp),
    .grant_id      (fp_gid),
    .busy          (fp_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input avalon_req_t obs, input avalon_req_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, RW'(obs), RW'(exp));
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic avalon_req_t mk_rd(input logic [31:0] addr);
    avalon_req_t r;
    r = '{read: 1'b1, write: 1'b0, address: addr, writedata: 32'h0, byte_enable: 4'hF};
    return r;
  endfunction

  initial begin
    avalon_req_t exp_w;
    logic [7:0]  rr_order;
    logic [0:0]  e;

    rst      = 1'b1;
    host_req = '0;
    mem_resp = '{readdata: 32'h0, waitrequest: 1'b1};
    repeat (3) step();

    chk("rst_busy", 64'(rr_busy), 64'd0);
    chk("rst_gid", 64'(rr_gid), 64'd0);
    chk_req("rst_mem", rr_mem_req, '0);
    chk("rst_wr0", 64'(rr_resp[0].waitrequest), 64'd1);
    chk("rst_wr1", 64'(rr_resp[1].waitrequest), 64'd1);
    chk("rst_rd0", 64'(rr_resp[0].readdata), 64'd0);
    chk("rst_fp_busy", 64'(fp_busy), 64'd0);

    // Single read from port 0, memory stalls two grant cycles.
    rst         = 1'b0;
    host_req[0] = mk_rd(32'h100);
    #1;
    chk("t1_idle_busy", 64'(rr_busy), 64'd0);
    chk("t1_idle_wr0", 64'(rr_resp[0].waitrequest), 64'd1);
    chk_req("t1_idle_mem", rr_mem_req, '0);
    step();
    chk("t1_busy", 64'(rr_busy), 64'd1);
    chk("t1_gid", 64'(rr_gid), 64'd0);
    chk_req("t1_mem", rr_mem_req, mk_rd(32'h100));
    chk("t1_wr0_stall", 64'(rr_resp[0].waitrequest), 64'd1);
    chk("t1_wr1_stall", 64'(rr_resp[1].waitrequest), 64'd1);
    step();
    chk("t1_wr0_stall2", 64'(rr_resp[0].waitrequest), 64'd1);
    step();
    mem_resp = '{readdata: 32'hDEADBEEF, waitrequest: 1'b0};
    #1;
    chk("t1_rd0", 64'(rr_resp[0].readdata), 64'hDEADBEEF);
    chk("t1_wr0_done", 64'(rr_resp[0].waitrequest), 64'd0);
    chk("t1_wr1_done", 64'(rr_resp[1].waitrequest), 64'd1);
    chk("t1_rd1", 64'(rr_resp[1].readdata), 64'd0);
    step();
    host_req[0] = '0;
    mem_resp    = '{readdata: 32'h0, waitrequest: 1'b1};
    #1;
    chk("t1_after_busy", 64'(rr_busy), 64'd0);
    chk_req("t1_after_mem", rr_mem_req, '0);

    // Contention: last_grant is 0 after t1, so RR order is 1,0,1,0,...; FP always 0.
    host_req[0] = mk_rd(32'h10);
    host_req[1] = mk_rd(32'h20);
    mem_resp    = '{readdata: 32'hA5A50000, waitrequest: 1'b0};
    rr_order    = 8'b0101_0101;
    #1;
    for (int g = 0; g < 8; g++) begin
      e = rr_order[g];
      chk("rr_gap_busy", 64'(rr_busy), 64'd0);
      step();
      chk("rr_gid", 64'(rr_gid), 64'(e));
      chk("rr_addr", 64'(rr_mem_req.address), e ? 64'h20 : 64'h10);
      chk("rr_wr_owner", 64'(rr_resp[e].waitrequest), 64'd0);
      chk("rr_wr_other", 64'(rr_resp[~e].waitrequest), 64'd1);
      chk("rr_rd_owner", 64'(rr_resp[e].readdata), 64'hA5A50000);
      chk("fp_gid", 64'(fp_gid), 64'd0);
      chk("fp_wr1_starved", 64'(fp_resp[1].waitrequest), 64'd1);
      step();
    end
    host_req[0] = '0;
    #1;
    step();
    chk("fp_release_gid", 64'(fp_gid), 64'd1);
    chk("fp_release_wr1", 64'(fp_resp[1].waitrequest), 64'd0);
    chk("rr_release_gid", 64'(rr_gid), 64'd1);
    step();
    host_req[1] = '0;
    mem_resp    = '{readdata: 32'h0, waitrequest: 1'b1};
    #1;
    chk("t2_end_busy", 64'(rr_busy), 64'd0);
    chk("t2_end_fp_busy", 64'(fp_busy), 64'd0);

    // Write pass-through on port 1.
    exp_w = '{read: 1'b0, write: 1'b1, address: 32'h2000, writedata: 32'h12345678, byte_enable: 4'b0011};
    host_req[1] = '{read: 1'b0, write: 1'b1, address: 32'h2000, writedata: 32'h12345678, byte_enable: 4'b0011};
    #1;
    chk_req("t3_idle_mem", rr_mem_req, '0);
    step();
    chk("t3_gid", 64'(rr_gid), 64'd1);
    chk_req("t3_mem", rr_mem_req, exp_w);
    chk("t3_wr1_stall", 64'(rr_resp[1].waitrequest), 64'd1);
    step();
    mem_resp.waitrequest = 1'b0;
    #1;
    chk("t3_wr1_done", 64'(rr_resp[1].waitrequest), 64'd0);
    chk("t3_busy", 64'(rr_busy), 64'd1);
    step();
    host_req[1]          = '0;
    mem_resp.waitrequest = 1'b1;
    #1;
    chk("t3_after_busy", 64'(rr_busy), 64'd0);
    chk_req("t3_after_mem", rr_mem_req, '0);

    // Reset mid-transfer, with last_grant=0 beforehand so port0-first proves it reset.
    host_req[0] = mk_rd(32'h300);
    host_req[1] = mk_rd(32'h400);
    mem_resp    = '{readdata: 32'h0BADF00D, waitrequest: 1'b0};
    #1;
    step();
    chk("t4_gid0", 64'(rr_gid), 64'd0);
    chk("t4_rd0", 64'(rr_resp[0].readdata), 64'h0BADF00D);
    step();
    mem_resp.waitrequest = 1'b1;
    #1;
    chk("t4_gap_busy", 64'(rr_busy), 64'd0);
    step();
    chk("t4_gid1", 64'(rr_gid), 64'd1);
    chk("t4_addr1", 64'(rr_mem_req.address), 64'h400);
    rst = 1'b1;
    step();
    chk("t4_rst_read", 64'(rr_mem_req.read), 64'd0);
    chk("t4_rst_write", 64'(rr_mem_req.write), 64'd0);
    chk("t4_rst_busy", 64'(rr_busy), 64'd0);
    chk("t4_rst_wr0", 64'(rr_resp[0].waitrequest), 64'd1);
    chk("t4_rst_wr1", 64'(rr_resp[1].waitrequest), 64'd1);
    chk("t4_rst_gid", 64'(rr_gid), 64'd0);
    rst = 1'b0;
    step();
    chk("t4_post_gid", 64'(rr_gid), 64'd0);
    chk("t4_post_busy", 64'(rr_busy), 64'd1);
    chk("t4_post_addr", 64'(rr_mem_req.address), 64'h300);
    host_req = '0;
    #1;
    step();
    chk("t4_clear_busy", 64'(rr_busy), 64'd0);

    // Owner abort: port0 drops its read, pending port1 follows after one IDLE.
    host_req[0] = mk_rd(32'h500);
    #1;
    step();
    chk("t5_gid0", 64'(rr_gid), 64'd0);
    chk("t5_busy", 64'(rr_busy), 64'd1);
    host_req[0] = '0;
    host_req[1] = mk_rd(32'h600);
    #1;
    chk("t5_drop_read", 64'(rr_mem_req.read), 64'd0);
    chk("t5_drop_wr1", 64'(rr_resp[1].waitrequest), 64'd1);
    step();
    chk("t5_idle_busy", 64'(rr_busy), 64'd0);
    chk("t5_idle_wr1", 64'(rr_resp[1].waitrequest), 64'd1);
    step();
    chk("t5_gid1", 64'(rr_gid), 64'd1);
    chk("t5_busy1", 64'(rr_busy), 64'd1);
    chk("t5_addr1", 64'(rr_mem_req.address), 64'h600);
    mem_resp.waitrequest = 1'b0;
    #1;
    chk("t5_wr1_done", 64'(rr_resp[1].waitrequest), 64'd0);
    step();
    host_req             = '0;
    mem_resp.waitrequest = 1'b1;
    #1;
    chk("t5_end_busy", 64'(rr_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
- Shares one memory-side Avalon-MM port between NUM_PORTS cache/core masters, e.g. instruction cache and data cache miss paths.
- Sits between the cache instances and the memory/bus fabric.
- Grants one requester at a time and holds the grant until that transfer completes.
- Policy is round-robin or fixed priority, selected by parameter.

Parameters:
- NUM_PORTS, 2, number of requesting masters (2..8).
- RR_ENABLE, 1, 1 = round-robin; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- host_avn_req  input  avalon_req_t[NUM_PORTS]  requests from masters.
- host_avn_resp  output  avalon_resp_t[NUM_PORTS]  responses to masters.
- mem_avn_req  output  avalon_req_t  request to memory.
- mem_avn_resp  input  avalon_resp_t  response from memory.
- grant_id  output  $clog2(NUM_PORTS)  index of the current owner (debug/perf).
- busy  output  1  a grant is active.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Struct fields used:
  - req: read, write, address[31:0], writedata[31:0], byte_enable[3:0].
  - resp: readdata[31:0], waitrequest.
- A transfer completes in the cycle where (read|write) && !waitrequest on mem. readdata is valid in that same cycle.
- Request: port i requests when host_avn_req[i].read | .write.
- FSM states: IDLE, GRANT.
- IDLE:
  - mem_avn_req all-zero.
  - Every host sees waitrequest=1.
  - If any port requests, select a winner, register owner<=winner, go to GRANT next cycle.
  - Arbitration costs exactly 1 cycle of latency.
- GRANT:
  - mem_avn_req = host_avn_req[owner], combinational pass-through.
  - host_avn_resp[owner] = mem_avn_resp.
  - Non-owners see waitrequest=1 and readdata=0.
- GRANT transitions:
  - On completion, last_grant<=owner and go to IDLE. The next grant is issued after a minimum 1-cycle IDLE gap, so no back-to-back re-arbitration.
  - If the owner drops both read and write before completion (protocol violation), return to IDLE. No transfer is counted.
- Round-robin:
  - Search starts at (last_grant+1) mod NUM_PORTS and wraps around; the first requester found wins.
  - last_grant resets to NUM_PORTS-1, so port 0 wins first.
- Fixed priority: the lowest requesting index wins. last_grant is ignored.
- Simultaneous events: new requests arriving during GRANT are held off by waitrequest=1 and arbitrated in the next IDLE. Requesters must hold their request stable.
- Reset:
  - owner=0, last_grant=NUM_PORTS-1, state=IDLE.
  - mem_avn_req all fields 0.
  - All host waitrequest=1, readdata=0.
  - grant_id=0, busy=0.
- Reset mid-transfer: deassert the mem request the next cycle and abandon the transfer.
- busy = (state==GRANT). grant_id = owner.
- No write buffering and no reordering. At most one outstanding transfer.

Decomposition:
- core.svh / shared package:
  - avalon_req_t, avalon_resp_t (existing).
  - Add localparam AVN_ADDR_W=32, AVN_DATA_W=32.
- One sub-module, rr_arbiter_core: a combinational mask-and-priority-encode that picks the winner from the request vector and last_grant. It is reusable by a future bus crossbar.
- FSM and muxing stay in avalon_mem_arbiter.

Test Plan:
- Single request: port0 read addr 0x100, mem waitrequest low 2 cycles after grant, readdata=0xDEADBEEF.
  - Expect 1-cycle arbitration delay, then port0 gets 0xDEADBEEF with waitrequest=0 in the completion cycle.
  - Port1 sees waitrequest=1 throughout.
- Contention RR: ports 0 and 1 both read continuously for 4 transfers each.
  - Expect grant order 0,1,0,1,…
  - IDLE gap of 1 cycle between grants.
  - last_grant alternates.
- Fixed priority (RR_ENABLE=0): both request continuously.
  - Port0 wins every time; port1 is starved until port0 deasserts.
- Write pass-through: port1 write addr 0x2000, data 0x12345678, byte_enable 4'b0011.
  - mem_avn_req shows identical fields only while owner=1.
  - Completes on the first !waitrequest.
- Reset mid-transfer: assert rst during GRANT with mem waitrequest=1.
  - Next cycle: mem read/write=0, busy=0, all host waitrequest=1.
  - After release, port0 wins first.
- Owner abort: port0 drops read while in GRANT.
  - FSM returns to IDLE next cycle.
  - A pending port1 request is then granted after 1 arbitration cycle.
